bcd_display_scanner: RTL

Sequential 5-digit multiplexed 7-segment display driver. Sits directly downstream of the 16-bit binary-to-BCD converter: captures its 20-bit packed BCD word on a load strobe, then time-multiplexes the five digits onto one shared segment bus with one-hot digit enables. Optional leading-zero blanking; non-decimal nibbles render as a dash.

---
 rtl/bcd_display_scanner_if.sv | 23 ++
 rtl/bcd_display_scanner.sv | 121 ++++++++++++
 2 files changed

// File: rtl/bcd_display_scanner_if.sv
// Bus bundle for the multiplexed BCD display scanner: the captured BCD word,
// its load strobe and blanking control in one direction, and the segment /
// digit-enable / frame outputs in the other.
interface bcd_display_scanner_if;
  logic [19:0] in_bcd_value;
  logic        in_load;
  logic        in_blank_zeros;
  logic [6:0]  out_seg;
  logic [4:0]  out_an;
  logic        out_frame;

  // Producer side (upstream converter / testbench) drives the value and controls.
  modport master (
    output in_bcd_value, in_load, in_blank_zeros,
    input  out_seg, out_an, out_frame
  );

  // The scanner itself.
  modport slave (
    input  in_bcd_value, in_load, in_blank_zeros,
    output out_seg, out_an, out_frame
  );
endinterface

// File: rtl/bcd_display_scanner.sv
// Five-digit time-multiplexed 7-segment driver. A snapshot of the packed BCD
// word is scanned digit by digit onto a shared segment bus with one-hot digit
// enables; optional leading-zero blanking; non-decimal nibbles show a dash.
// Segment and enable outputs are registered in board polarity.
module bcd_display_scanner #(
  parameter int SCAN_DIV   = 50000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  bcd_display_scanner_if.slave  bus
);

  localparam int              CNT_W   = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);
  localparam logic [6:0]      SEG_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [4:0]      AN_OFF  = ACTIVE_LOW ? 5'h1F : 5'h00;

  // Logical (active-high) segment pattern {g,f,e,d,c,b,a} for one nibble.
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    case (nib)
      4'd0:    seg_decode = 7'h3F;
      4'd1:    seg_decode = 7'h06;
      4'd2:    seg_decode = 7'h5B;
      4'd3:    seg_decode = 7'h4F;
      4'd4:    seg_decode = 7'h66;
      4'd5:    seg_decode = 7'h6D;
      4'd6:    seg_decode = 7'h7D;
      4'd7:    seg_decode = 7'h07;
      4'd8:    seg_decode = 7'h7F;
      4'd9:    seg_decode = 7'h6F;
      default: seg_decode = 7'h40;  // dash for 10..15
    endcase
  endfunction

  logic [CNT_W-1:0] presc_q, presc_d;
  logic [2:0]       idx_q,   idx_d;
  logic [19:0]      snap_q,  snap_d;
  logic             wrap_q,  wrap_d;
  logic             frame_q, frame_d;
  logic [6:0]       seg_q,   seg_d;
  logic [4:0]       an_q,    an_d;

  logic             slot_end;
  logic [4:1]       lead_zero;   // digit i and everything above it is zero
  logic [3:0]       cur_nib;
  logic             cur_lead_zero;
  logic [6:0]       seg_logic;
  logic [4:0]       an_logic;

  // Next-state for prescaler, digit index, snapshot and the output pipeline.
  always_comb begin
    // NOTE: every signal written here gets a value before any branch, so no
    // path can leave one unassigned and infer a latch.
    presc_d       = presc_q;
    idx_d         = idx_q;
    snap_d        = snap_q;
    wrap_d        = 1'b0;
    cur_nib       = snap_q[3:0];
    cur_lead_zero = 1'b0;
    lead_zero     = '0;

    slot_end = (presc_q == CNT_MAX);

    if (slot_end) begin
      presc_d = '0;
      idx_d   = (idx_q == 3'd4) ? 3'd0 : idx_q + 3'd1;
      wrap_d  = (idx_q == 3'd4);
    end else begin
      presc_d = presc_q + 1'b1;
    end

    if (bus.in_load) snap_d = bus.in_bcd_value;

    for (int i = 1; i <= 4; i++) lead_zero[i] = ~|(snap_q >> (4 * i));

    case (idx_q)
      3'd1:    begin cur_nib = snap_q[7:4];   cur_lead_zero = lead_zero[1]; end
      3'd2:    begin cur_nib = snap_q[11:8];  cur_lead_zero = lead_zero[2]; end
      3'd3:    begin cur_nib = snap_q[15:12]; cur_lead_zero = lead_zero[3]; end
      3'd4:    begin cur_nib = snap_q[19:16]; cur_lead_zero = lead_zero[4]; end
      default: begin cur_nib = snap_q[3:0];   cur_lead_zero = 1'b0;         end
    endcase

    // Units digit never has a lead-zero flag, so "0" always shows.
    seg_logic = (bus.in_blank_zeros && cur_lead_zero) ? 7'h00 : seg_decode(cur_nib);
    an_logic  = 5'(5'b00001 << idx_q);

    seg_d   = ACTIVE_LOW ? ~seg_logic : seg_logic;
    an_d    = ACTIVE_LOW ? ~an_logic  : an_logic;
    frame_d = wrap_q;
  end

  // State and output registers; reset blanks the display and clears the snapshot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q <= '0;
      idx_q   <= 3'd0;
      snap_q  <= '0;
      wrap_q  <= 1'b0;
      frame_q <= 1'b0;
      seg_q   <= SEG_OFF;
      an_q    <= AN_OFF;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      presc_q <= presc_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      wrap_q  <= wrap_d;
      frame_q <= frame_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
    end
  end

  assign bus.out_seg   = seg_q;
  assign bus.out_an    = an_q;
  assign bus.out_frame = frame_q;

endmodule
